// File: rtl/breath_led_mc.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// breath_led_mc
// Multi-channel breathing-LED PWM generator. A single tick prescaler and PWM
// frame counter are shared by all channels. A common triangular "breathe"
// duty ramps one step per PWM frame. Each channel picks its own duty source:
// off, a static level, the ramp, or the ramp mirrored (anti-phase).
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-high
//   pause      freezes the breathe ramp at frame boundaries (counters run on)
//   ch_mode    per-channel mode, channel i at [2i+1:2i]
//              00 off, 01 static, 10 breathe, 11 breathe anti-phase
//   ch_level   per-channel static duty, channel i at [PWM_W*i +: PWM_W]
//   led        registered LED drive, 1 = on
//   frame_end  one-clock pulse on the last clock of every PWM frame
//   ramp_dir   current ramp direction, 1 = rising
// ---------------------------------------------------------------------------
module breath_led_mc #(
  parameter int CH_NUM       = 4,
  parameter int CNT_TICK_MAX = 49,
  parameter int CNT_PWM_MAX  = 999,
  parameter int PWM_W        = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pause,
  input  logic [2*CH_NUM-1:0]       ch_mode,
  input  logic [PWM_W*CH_NUM-1:0]   ch_level,
  output logic [CH_NUM-1:0]         led,
  output logic                      frame_end,
  output logic                      ramp_dir
);

  // A prescaler of 0 still needs a one-bit counter.
  localparam int TICK_W = (CNT_TICK_MAX > 0) ? $clog2(CNT_TICK_MAX + 1) : 1;

  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(CNT_TICK_MAX);
  localparam logic [TICK_W-1:0] TICK_ONE = TICK_W'(1);
  localparam logic [PWM_W-1:0]  PWM_MAX  = PWM_W'(CNT_PWM_MAX);
  localparam logic [PWM_W-1:0]  PWM_ONE  = PWM_W'(1);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_STATIC  = 2'b01,
    MODE_BREATHE = 2'b10,
    MODE_ANTI    = 2'b11
  } mode_e;

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [PWM_W-1:0]  pwm_cnt_q,  pwm_cnt_d;
  logic [PWM_W-1:0]  duty_q,     duty_d;
  logic              ramp_dir_q, ramp_dir_d;
  logic              frame_end_q, frame_end_d;
  logic [CH_NUM-1:0] led_q,      led_d;

  logic tick;
  logic frame_last;
  logic ramp_step;

  // -------------------------------------------------------------------------
  // Shared timebase
  // -------------------------------------------------------------------------
  assign tick       = (tick_cnt_q == TICK_MAX);
  assign frame_last = tick && (pwm_cnt_q == PWM_MAX);
  assign ramp_step  = frame_last && !pause;

  always_comb begin
    tick_cnt_d = tick ? '0 : (tick_cnt_q + TICK_ONE);

    pwm_cnt_d = pwm_cnt_q;
    if (tick) begin
      pwm_cnt_d = (pwm_cnt_q == PWM_MAX) ? '0 : (pwm_cnt_q + PWM_ONE);
    end

    // frame_end is computed from the next counter state so the registered
    // pulse lines up with the clock where the counters show the frame's last
    // position, rather than trailing it by one clock.
    frame_end_d = (tick_cnt_d == TICK_MAX) && (pwm_cnt_d == PWM_MAX);
  end

  // -------------------------------------------------------------------------
  // Breathe ramp: triangle between 0 and PWM_MAX, one step per frame.
  // At each extreme the ramp turns around and immediately steps away, so
  // each extreme value is held for exactly one frame.
  // -------------------------------------------------------------------------
  always_comb begin
    duty_d     = duty_q;
    ramp_dir_d = ramp_dir_q;
    if (ramp_step) begin
      if (ramp_dir_q) begin
        if (duty_q == PWM_MAX) begin
          ramp_dir_d = 1'b0;
          duty_d     = PWM_MAX - PWM_ONE;
        end else begin
          duty_d = duty_q + PWM_ONE;
        end
      end else begin
        if (duty_q == '0) begin
          ramp_dir_d = 1'b1;
          duty_d     = PWM_ONE;
        end else begin
          duty_d = duty_q - PWM_ONE;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Per-channel duty select and PWM compare
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
    mode_e            mode;
    logic [PWM_W-1:0] level;
    logic [PWM_W-1:0] eff_duty;

    assign mode  = mode_e'(ch_mode[2*gi +: 2]);
    assign level = ch_level[PWM_W*gi +: PWM_W];

    always_comb begin
      eff_duty = '0;
      case (mode)
        MODE_OFF:     eff_duty = '0;
        MODE_STATIC:  eff_duty = level;
        MODE_BREATHE: eff_duty = duty_q;
        // duty_q never exceeds PWM_MAX, so the mirror cannot underflow.
        MODE_ANTI:    eff_duty = PWM_MAX - duty_q;
        default:      eff_duty = '0;
      endcase
    end

    // A level above PWM_MAX is always greater than pwm_cnt, i.e. fully on.
    assign led_d[gi] = (pwm_cnt_q < eff_duty);
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q  <= '0;
      pwm_cnt_q   <= '0;
      duty_q      <= '0;
      ramp_dir_q  <= 1'b1;
      frame_end_q <= 1'b0;
      led_q       <= '0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      duty_q      <= duty_d;
      ramp_dir_q  <= ramp_dir_d;
      frame_end_q <= frame_end_d;
      led_q       <= led_d;
    end
  end

  assign led       = led_q;
  assign frame_end = frame_end_q;
  assign ramp_dir  = ramp_dir_q;

endmodule

// File: tb/tb_breath_led_mc.sv
`timescale 1ns/1ps
// Directed bench for breath_led_mc with a 20-clock frame (2 clocks/tick,
// 10 ticks/frame). LED outputs are captured per frame as 20-bit patterns,
// sampled on the falling edge. Because led has one clock of latency, the
// window for a frame starting at counter state s is samples s+1..s+20, and
// frame_end shows up at window index 18.
module tb_breath_led_mc;

  localparam int CH    = 4;
  localparam int TM    = 1;
  localparam int PM    = 9;
  localparam int PW    = 4;
  localparam int FRAME = 20;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pause = 1'b0;
  logic [2*CH-1:0]   ch_mode = '0;
  logic [PW*CH-1:0]  ch_level = '0;
  logic [CH-1:0]     led;
  logic              frame_end;
  logic              ramp_dir;

  breath_led_mc #(
    .CH_NUM      (CH),
    .CNT_TICK_MAX(TM),
    .CNT_PWM_MAX (PM),
    .PWM_W       (PW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pause    (pause),
    .ch_mode  (ch_mode),
    .ch_level (ch_level),
    .led      (led),
    .frame_end(frame_end),
    .ramp_dir (ramp_dir)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [FRAME-1:0] pat [CH];
  int               fe_cnt;
  int               fe_pos;
  logic             dir_first;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Expected 20-sample pattern for duty d: high while pwm < d, 2 clocks/tick.
  function automatic logic [FRAME-1:0] exp_pat(input int d);
    logic [FRAME-1:0] p;
    p = '0;
    for (int k = 0; k < FRAME; k++) p[k] = (k < 2*d);
    return p;
  endfunction

  // Hand-derived triangle: frames 0..9 rise 0..9, 10..18 fall 8..0, 19 -> 1.
  function automatic int bduty(input int f);
    if (f <= 9)  return f;
    if (f <= 18) return 18 - f;
    return f - 18;
  endfunction

  function automatic logic bdir(input int f);
    return (f <= 9) || (f >= 19);
  endfunction

  task automatic run_frame();
    fe_cnt = 0;
    fe_pos = -1;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) pat[c][k] = led[c];
      if (k == 0) dir_first = ramp_dir;
      if (frame_end) begin
        fe_cnt++;
        fe_pos = k;
      end
    end
  endtask

  task automatic check_fe(input string tag);
    check_eq({tag, "_fe_cnt"}, fe_cnt, 1);
    check_eq({tag, "_fe_pos"}, fe_pos, 18);
  endtask

  // One-clock reset; returns at the falling edge showing the reset state.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_mode(input int c, input logic [1:0] m);
    ch_mode[2*c +: 2] = m;
  endtask

  task automatic set_level(input int c, input logic [PW-1:0] l);
    ch_level[PW*c +: PW] = l;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state, all channels off ----------------
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_led", led, 0);
    check_eq("rst_frame_end", frame_end, 0);
    check_eq("rst_ramp_dir", ramp_dir, 1);
    for (int f = 0; f < 2; f++) begin
      run_frame();
      for (int c = 0; c < CH; c++)
        check_eq($sformatf("off_f%0d_ch%0d", f, c), pat[c], 0);
      check_fe($sformatf("off_f%0d", f));
    end

    // ---------------- static levels on channel 0 ----------------
    do_reset();
    set_mode(0, 2'b01);
    set_level(0, 4'd3);
    run_frame();
    check_eq("static3_ch0", pat[0], exp_pat(3));
    check_eq("static3_ch1", pat[1], 0);
    check_fe("static3");
    run_frame();
    check_eq("static3b_ch0", pat[0], exp_pat(3));
    set_level(0, 4'd0);
    run_frame();
    check_eq("static0_ch0", pat[0], 0);
    set_level(0, 4'd15);
    run_frame();
    check_eq("static15_ch0", pat[0], {FRAME{1'b1}});
    check_fe("static15");

    // ---------------- breathe and anti-phase from reset ----------------
    do_reset();
    set_mode(0, 2'b00);
    set_mode(1, 2'b10);
    set_mode(2, 2'b11);
    check_eq("br_rst_dir", ramp_dir, 1);
    for (int f = 0; f < 20; f++) begin
      run_frame();
      check_eq($sformatf("br_f%0d_ch1", f), pat[1], exp_pat(bduty(f)));
      check_eq($sformatf("anti_f%0d_ch2", f), pat[2], exp_pat(PM - bduty(f)));
      check_eq($sformatf("sum_f%0d", f), $countones(pat[1]) + $countones(pat[2]), 18);
      check_eq($sformatf("dir_f%0d", f), dir_first, bdir(f));
    end
    check_fe("br_last");

    // ---------------- pause at duty 4 ----------------
    do_reset();
    set_mode(2, 2'b00);
    for (int f = 0; f < 4; f++) begin
      run_frame();
      check_eq($sformatf("pre_pause_f%0d", f), pat[1], exp_pat(f));
    end
    pause = 1'b1;
    for (int f = 4; f < 7; f++) begin
      run_frame();
      check_eq($sformatf("pause_f%0d", f), pat[1], exp_pat(4));
      check_eq($sformatf("pause_dir_f%0d", f), dir_first, 1);
      check_fe($sformatf("pause_f%0d", f));
    end
    pause = 1'b0;
    run_frame();
    check_eq("resume_f7", pat[1], exp_pat(4));
    run_frame();
    check_eq("resume_f8", pat[1], exp_pat(5));
    run_frame();
    check_eq("resume_f9", pat[1], exp_pat(6));

    // ---------------- reset mid-frame at duty 6 falling ----------------
    do_reset();
    set_mode(0, 2'b01);
    set_level(0, 4'd15);
    for (int f = 0; f < 12; f++) run_frame();
    repeat (7) @(negedge clk);
    check_eq("mid_led", led, 4'b0011);
    check_eq("mid_dir", ramp_dir, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_rst_led", led, 0);
    check_eq("mid_rst_frame_end", frame_end, 0);
    check_eq("mid_rst_dir", ramp_dir, 1);
    run_frame();
    check_eq("post_rst_f0_ch0", pat[0], {FRAME{1'b1}});
    check_eq("post_rst_f0_ch1", pat[1], exp_pat(0));
    check_fe("post_rst_f0");
    run_frame();
    check_eq("post_rst_f1_ch1", pat[1], exp_pat(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
